seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the calculator's multiplexed seven-segment display driver.
- Watches the time-multiplexed anode/seg/dp bus and rebuilds the four displayed digit codes.
- Publishes a complete frame once every position has been captured.
- Used for on-board loopback self-check and as a synthesizable display monitor in system benches.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/seg7_to_code.sv | 31 +++
 rtl/seg_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared seven-segment encodings and digit codes for the calculator display path.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package calc_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_MINUS = 4'hA;
   localparam logic [3:0] CODE_ERR   = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PUBLISH = 1'b1
   } frame_state_e;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational reverse map of an active-low seven-segment pattern to a digit code.
// Unrecognised patterns yield CODE_ERR with invalid_o raised.
module seg7_to_code
   import calc_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] code_o,
   output logic       invalid_o
);

   always_comb begin
      code_o    = CODE_ERR;
      invalid_o = 1'b0;
      case (seg_i)
         SEG_0:     code_o = 4'h0;
         SEG_1:     code_o = 4'h1;
         SEG_2:     code_o = 4'h2;
         SEG_3:     code_o = 4'h3;
         SEG_4:     code_o = 4'h4;
         SEG_5:     code_o = 4'h5;
         SEG_6:     code_o = 4'h6;
         SEG_7:     code_o = 4'h7;
         SEG_8:     code_o = 4'h8;
         SEG_9:     code_o = 4'h9;
         SEG_MINUS: code_o = CODE_MINUS;
         SEG_BLANK: code_o = CODE_BLANK;
         default:   invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four digit codes shown on a multiplexed seven-segment bus and
// publishes them as a frame once every position has been captured.
module seg_scan_decoder
   import calc_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int TO_W           = 17
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [6:0] seg,
   input  logic       dp,
   input  logic [3:0] anode,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [3:0] dp_mask,
   output logic       frame_valid,
   output logic       frame_changed,
   output logic       seg_err,
   output logic       scan_lost
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_CAP = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_SAT = CW'(SETTLE_CYCLES);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

   logic [3:0]      anode_q, anode_p_q;
   logic [6:0]      seg_q, seg_p_q;
   logic            dp_q, dp_p_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TO_W-1:0] to_q, to_d;
   frame_state_e    state_q, state_d;
   logic [3:0]      mask_q, mask_d;
   logic            err_q, err_d;
   logic [3:0][3:0] shadow_code_q, shadow_code_d;
   logic [3:0]      shadow_dp_q, shadow_dp_d;
   logic [3:0][3:0] digits_q, digits_d;
   logic [3:0]      dp_mask_q, dp_mask_d;
   logic            fv_q, fv_d, fc_q, fc_d, seg_err_q, seg_err_d, lost_q, lost_d;
   logic            pos_valid, same, capture, dec_invalid;
   logic [1:0]      pos;
   logic [3:0]      dec_code;

   seg7_to_code u_dec (
      .seg_i     (seg_q),
      .code_o    (dec_code),
      .invalid_o (dec_invalid)
   );

   // Only a single low anode bit names a position; anything else is bus noise.
   always_comb begin
      pos_valid = 1'b1;
      pos       = 2'd0;
      case (anode_q)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: pos_valid = 1'b0;
      endcase
   end

   assign same = ({anode_q, seg_q, dp_q} == {anode_p_q, seg_p_q, dp_p_q});

   // Counter parks above the capture value so a long dwell captures exactly once.
   always_comb begin
      if (!pos_valid || !same) cnt_d = '0;
      else if (cnt_q >= CNT_CAP) cnt_d = CNT_SAT;
      else cnt_d = cnt_q + CW'(1);
   end

   assign capture = pos_valid && (cnt_d == CNT_CAP);

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      err_d         = err_q;
      shadow_code_d = shadow_code_q;
      shadow_dp_d   = shadow_dp_q;
      digits_d      = digits_q;
      dp_mask_d     = dp_mask_q;
      fv_d          = 1'b0;
      fc_d          = 1'b0;
      seg_err_d     = seg_err_q;
      lost_d        = lost_q;
      to_d          = to_q;

      if (state_q == ST_PUBLISH) begin
         digits_d  = shadow_code_q;
         dp_mask_d = shadow_dp_q;
         fv_d      = 1'b1;
         fc_d      = (shadow_code_q != digits_q) || (shadow_dp_q != dp_mask_q);
         seg_err_d = err_q;
         mask_d    = '0;
         err_d     = 1'b0;
         state_d   = ST_COLLECT;
      end

      // A capture in the publish cycle seeds the next frame after the clear above.
      if (capture) begin
         shadow_code_d[pos] = dec_code;
         shadow_dp_d[pos]   = ~dp_q;
         mask_d[pos]        = 1'b1;
         if (dec_invalid) err_d = 1'b1;
      end

      if (state_q == ST_COLLECT && mask_d == 4'hF) state_d = ST_PUBLISH;

      if (capture) to_d = '0;
      else if (to_q != TO_MAX) to_d = to_q + TO_W'(1);

      if (fv_d) lost_d = 1'b0;
      else if (to_q == TO_MAX) lost_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         anode_q       <= 4'hF;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
         anode_p_q     <= 4'hF;
         seg_p_q       <= SEG_BLANK;
         dp_p_q        <= 1'b1;
         cnt_q         <= '0;
         to_q          <= '0;
         state_q       <= ST_COLLECT;
         mask_q        <= '0;
         err_q         <= 1'b0;
         shadow_code_q <= {4{CODE_BLANK}};
         shadow_dp_q   <= '0;
         digits_q      <= {4{CODE_BLANK}};
         dp_mask_q     <= '0;
         fv_q          <= 1'b0;
         fc_q          <= 1'b0;
         seg_err_q     <= 1'b0;
         lost_q        <= 1'b0;
      end else begin
         anode_q       <= anode;
         seg_q         <= seg;
         dp_q          <= dp;
         anode_p_q     <= anode_q;
         seg_p_q       <= seg_q;
         dp_p_q        <= dp_q;
         cnt_q         <= cnt_d;
         to_q          <= to_d;
         state_q       <= state_d;
         mask_q        <= mask_d;
         err_q         <= err_d;
         shadow_code_q <= shadow_code_d;
         shadow_dp_q   <= shadow_dp_d;
         digits_q      <= digits_d;
         dp_mask_q     <= dp_mask_d;
         fv_q          <= fv_d;
         fc_q          <= fc_d;
         seg_err_q     <= seg_err_d;
         lost_q        <= lost_d;
      end
   end

   assign digit1        = digits_q[3];
   assign digit2        = digits_q[2];
   assign digit3        = digits_q[1];
   assign digit4        = digits_q[0];
   assign dp_mask       = dp_mask_q;
   assign frame_valid   = fv_q;
   assign frame_changed = fc_q;
   assign seg_err       = seg_err_q;
   assign scan_lost     = lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives a multiplexed display bus and
// checks published frames against hand-computed expectations.
module tb_seg_scan_decoder;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P6 = 7'b0000010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] PM = 7'b0111111;
   localparam logic [6:0] PB = 7'b1111111;
   localparam logic [6:0] PX = 7'b1010101;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] anode;
   logic [3:0] digit1, digit2, digit3, digit4, dp_mask;
   logic       frame_valid, frame_changed, seg_err, scan_lost;

   int checks = 0;
   int failures = 0;
   int fv_cnt = 0;
   int orphan_fc = 0;
   logic last_fc = 1'b0;
   logic last_lost = 1'b0;

   typedef struct {
      logic [6:0]  s3, s2, s1, s0;
      logic [3:0]  dpn;
      logic [15:0] exp_dig;
      logic [3:0]  exp_dpm;
      logic        exp_fc;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   seg_scan_decoder dut (
      .clk_in        (clk),
      .reset         (reset),
      .seg           (seg),
      .dp            (dp),
      .anode         (anode),
      .digit1        (digit1),
      .digit2        (digit2),
      .digit3        (digit3),
      .digit4        (digit4),
      .dp_mask       (dp_mask),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .seg_err       (seg_err),
      .scan_lost     (scan_lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_cnt++;
         last_fc   = frame_changed;
         last_lost = scan_lost;
      end
      if (frame_changed === 1'b1 && frame_valid !== 1'b1) orphan_fc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic show_pos(input int p, input logic [6:0] sg, input logic dpn, input int dwell);
      anode = ~(4'b0001 << p);
      seg   = sg;
      dp    = dpn;
      hold(dwell);
   endtask

   task automatic scan(input logic [6:0] s3, s2, s1, s0, input logic [3:0] dpn, input int dwell);
      show_pos(3, s3, dpn[3], dwell);
      show_pos(2, s2, dpn[2], dwell);
      show_pos(1, s1, dpn[1], dwell);
      show_pos(0, s0, dpn[0], dwell);
   endtask

   function automatic logic [15:0] digits();
      return {digit1, digit2, digit3, digit4};
   endfunction

   initial begin
      int fv0;
      int n;

      vecs[0] = '{P1, P2, P3, P4, 4'b1111, 16'h1234, 4'b0000, 1'b0, 1'b0};
      vecs[1] = '{P1, P2, P3, P9, 4'b1111, 16'h1239, 4'b0000, 1'b1, 1'b0};
      vecs[2] = '{PM, PX, P0, P7, 4'b1101, 16'hAE07, 4'b0010, 1'b1, 1'b1};
      vecs[3] = '{P5, P6, P8, PB, 4'b1111, 16'h568F, 4'b0000, 1'b1, 1'b0};
      vecs[4] = '{P9, P0, P7, P6, 4'b0110, 16'h9076, 4'b1001, 1'b1, 1'b0};
      vecs[5] = '{P9, P0, P7, P6, 4'b0111, 16'h9076, 4'b1000, 1'b1, 1'b0};
      vecs[6] = '{P9, P0, P7, P6, 4'b0111, 16'h9076, 4'b1000, 1'b0, 1'b0};

      // Clock/reset
      reset = 1'b0;
      anode = 4'hF;
      seg   = PB;
      dp    = 1'b1;
      hold(4);
      check("rst_digits", 32'(digits()), 32'hFFFF);
      check("rst_dpmask", 32'(dp_mask), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_fc", 32'(frame_changed), 32'h0);
      check("rst_err", 32'(seg_err), 32'h0);
      check("rst_lost", 32'(scan_lost), 32'h0);
      reset = 1'b1;
      hold(2);

      // First frame "1234": exact latency from the last position to frame_valid.
      show_pos(3, P1, 1'b1, 8);
      show_pos(2, P2, 1'b1, 8);
      show_pos(1, P3, 1'b1, 8);
      anode = 4'b1110;
      seg   = P4;
      dp    = 1'b1;
      hold(5);
      check("lat_early_fv", 32'(frame_valid), 32'h0);
      check("lat_fv_cnt", 32'(fv_cnt), 32'h0);
      hold(1);
      check("lat_fv", 32'(frame_valid), 32'h1);
      check("lat_fc", 32'(frame_changed), 32'h1);
      check("lat_digits", 32'(digits()), 32'h1234);
      check("lat_dpmask", 32'(dp_mask), 32'h0);
      check("lat_err", 32'(seg_err), 32'h0);
      hold(1);
      check("lat_pulse_end", 32'(frame_valid), 32'h0);
      hold(2);
      check("lat_one_frame", 32'(fv_cnt), 32'h1);

      // Table-driven full scans
      for (int i = 0; i < 7; i++) begin
         fv0 = fv_cnt;
         scan(vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0, vecs[i].dpn, 8);
         hold(2);
         check($sformatf("v%0d_frames", i), 32'(fv_cnt - fv0), 32'h1);
         check($sformatf("v%0d_digits", i), 32'(digits()), 32'(vecs[i].exp_dig));
         check($sformatf("v%0d_dpmask", i), 32'(dp_mask), 32'(vecs[i].exp_dpm));
         check($sformatf("v%0d_fc", i), 32'(last_fc), 32'(vecs[i].exp_fc));
         check($sformatf("v%0d_err", i), 32'(seg_err), 32'(vecs[i].exp_err));
      end

      // Re-capture of a position: the latest value wins.
      fv0 = fv_cnt;
      show_pos(3, P1, 1'b1, 8);
      show_pos(2, P2, 1'b1, 8);
      show_pos(3, P7, 1'b1, 8);
      show_pos(1, P3, 1'b1, 8);
      show_pos(0, P4, 1'b1, 8);
      hold(2);
      check("recap_frames", 32'(fv_cnt - fv0), 32'h1);
      check("recap_digits", 32'(digits()), 32'h7234);

      // Dwell of 3 stable samples never captures; then idle into timeout.
      fv0 = fv_cnt;
      for (int r = 0; r < 2; r++) scan(P5, P6, P7, P8, 4'b1111, 3);
      anode = 4'hF;
      seg   = PB;
      hold(4);
      check("short_frames", 32'(fv_cnt - fv0), 32'h0);
      check("short_digits", 32'(digits()), 32'h7234);
      check("short_lost", 32'(scan_lost), 32'h0);
      n = 0;
      while (n < 70000 && scan_lost !== 1'b1) begin
         hold(1);
         n++;
      end
      check("timeout_lost", 32'(scan_lost), 32'h1);
      check("timeout_window", 32'(n >= 65400 && n <= 65540), 32'h1);

      // Full valid scan recovers: scan_lost drops together with frame_valid.
      fv0 = fv_cnt;
      show_pos(3, P1, 1'b1, 8);
      show_pos(2, P2, 1'b1, 8);
      show_pos(1, P3, 1'b1, 8);
      check("lost_held", 32'(scan_lost), 32'h1);
      show_pos(0, P4, 1'b1, 8);
      check("recover_frames", 32'(fv_cnt - fv0), 32'h1);
      check("recover_lost_at_fv", 32'(last_lost), 32'h0);
      check("recover_lost", 32'(scan_lost), 32'h0);
      check("recover_digits", 32'(digits()), 32'h1234);

      // Invalid anode patterns interleaved with valid positions are ignored.
      fv0 = fv_cnt;
      show_pos(3, P2, 1'b1, 8);
      anode = 4'b1001; seg = P1; hold(20);
      show_pos(2, P4, 1'b1, 8);
      anode = 4'b1111; seg = P3; hold(20);
      show_pos(1, P6, 1'b1, 8);
      anode = 4'b0000; seg = P5; hold(20);
      check("inval_partial", 32'(fv_cnt - fv0), 32'h0);
      show_pos(0, P8, 1'b1, 8);
      hold(2);
      check("inval_frames", 32'(fv_cnt - fv0), 32'h1);
      check("inval_digits", 32'(digits()), 32'h2468);

      // Reset mid-frame discards the partial capture.
      show_pos(3, P5, 1'b1, 8);
      show_pos(2, P6, 1'b1, 8);
      reset = 1'b0;
      hold(3);
      check("midrst_digits", 32'(digits()), 32'hFFFF);
      check("midrst_dpmask", 32'(dp_mask), 32'h0);
      check("midrst_fv", 32'(frame_valid), 32'h0);
      reset = 1'b1;
      fv0 = fv_cnt;
      show_pos(1, P7, 1'b1, 8);
      show_pos(0, P8, 1'b1, 8);
      hold(2);
      check("midrst_no_frame", 32'(fv_cnt - fv0), 32'h0);
      scan(P5, P6, P7, P8, 4'b1111, 8);
      hold(2);
      check("midrst_frames", 32'(fv_cnt - fv0), 32'h1);
      check("midrst_final", 32'(digits()), 32'h5678);
      check("midrst_fc", 32'(last_fc), 32'h1);

      check("fc_without_fv", 32'(orphan_fc), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
